// File: rtl/car_flow_if.sv
// Car flow counter bus: the two debounced beam sensors in and the occupancy/status outputs.
// Ports (modport slave = counter side):
//   sensor_a, sensor_b : beam-blocked inputs (outer, inner)
//   count              : registered occupancy
//   full, empty        : occupancy flags
//   entry_pulse, exit_pulse, err_pulse : one-cycle event strobes
//   fault              : held in WAIT_CLR after a stall timeout
interface car_flow_if #(
  parameter int CNT_W = 4
);
  logic             sensor_a;
  logic             sensor_b;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             entry_pulse;
  logic             exit_pulse;
  logic             err_pulse;
  logic             fault;

  modport master (
    output sensor_a, sensor_b,
    input  count, full, empty, entry_pulse, exit_pulse, err_pulse, fault
  );

  modport slave (
    input  sensor_a, sensor_b,
    output count, full, empty, entry_pulse, exit_pulse, err_pulse, fault
  );
endinterface

// File: rtl/car_flow_counter.sv
// Two-beam car flow counter. A car entering blocks a, then a+b, then b, then clears;
// an exit is the mirror. Each completed passage moves the occupancy count by one,
// saturating at 0 and CAPACITY (saturation reports err_pulse instead).
// A passage that stalls for TIMEOUT_CYC cycles parks the FSM in WAIT_CLR with fault
// raised until both beams are clear again.
// Ports:
//   clk_slow : the only clock (1 kHz), rising edge
//   rst      : synchronous active-high reset
//   bus      : car_flow_if slave (sensors in, count/flags/pulses out)
module car_flow_counter #(
  parameter int CAPACITY    = 15,
  parameter int CNT_W       = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic       clk_slow,
  input  logic       rst,
  car_flow_if.slave  bus
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A, WAIT_CLR
  } state_e;

  state_e           state_q, state_d;
  logic [TW-1:0]    stall_q, stall_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             entry_q, entry_d;
  logic             exit_q, exit_d;
  logic             err_q, err_d;
  logic             fault_q, fault_d;

  logic [1:0] ab;
  state_e     nxt;
  logic       ev_in, ev_out, tracking, timeout;

  // Passage sequencing from the sampled beam pair.
  always_comb begin
    ab     = {bus.sensor_a, bus.sensor_b};
    nxt    = state_q;
    ev_in  = 1'b0;
    ev_out = 1'b0;
    case (state_q)
      IDLE: case (ab)
        2'b10:   nxt = IN_A;
        2'b01:   nxt = OUT_B;
        2'b11:   nxt = WAIT_CLR;
        default: nxt = IDLE;
      endcase
      IN_A: case (ab)
        2'b11:   nxt = IN_AB;
        2'b00:   nxt = IDLE;
        2'b01:   nxt = WAIT_CLR;
        default: nxt = IN_A;
      endcase
      IN_AB: case (ab)
        2'b01:   nxt = IN_B;
        2'b10:   nxt = IN_A;
        2'b00:   nxt = WAIT_CLR;
        default: nxt = IN_AB;
      endcase
      IN_B: case (ab)
        2'b00:   begin nxt = IDLE; ev_in = 1'b1; end
        2'b11:   nxt = IN_AB;
        2'b10:   nxt = WAIT_CLR;
        default: nxt = IN_B;
      endcase
      OUT_B: case (ab)
        2'b11:   nxt = OUT_BA;
        2'b00:   nxt = IDLE;
        2'b10:   nxt = WAIT_CLR;
        default: nxt = OUT_B;
      endcase
      OUT_BA: case (ab)
        2'b10:   nxt = OUT_A;
        2'b01:   nxt = OUT_B;
        2'b00:   nxt = WAIT_CLR;
        default: nxt = OUT_BA;
      endcase
      OUT_A: case (ab)
        2'b00:   begin nxt = IDLE; ev_out = 1'b1; end
        2'b11:   nxt = OUT_BA;
        2'b01:   nxt = WAIT_CLR;
        default: nxt = OUT_A;
      endcase
      default: nxt = (ab == 2'b00) ? IDLE : WAIT_CLR;
    endcase
  end

  // Stall timer and next-state/output computation.
  always_comb begin
    // Timer only runs while a passage is in progress and not moving.
    tracking = (state_q != IDLE) && (state_q != WAIT_CLR) && (nxt == state_q);
    timeout  = tracking && (stall_q == TW'(TIMEOUT_CYC - 1));

    state_d = timeout ? WAIT_CLR : nxt;
    stall_d = (tracking && !timeout) ? stall_q + 1'b1 : '0;

    fault_d = fault_q;
    if (timeout)
      fault_d = 1'b1;
    else if (state_q == WAIT_CLR && nxt == IDLE)
      fault_d = 1'b0;

    count_d = count_q;
    entry_d = 1'b0;
    exit_d  = 1'b0;
    err_d   = 1'b0;
    if (ev_in) begin
      if (count_q == CNT_W'(CAPACITY)) err_d = 1'b1;
      else begin
        count_d = count_q + 1'b1;
        entry_d = 1'b1;
      end
    end else if (ev_out) begin
      if (count_q == '0) err_d = 1'b1;
      else begin
        count_d = count_q - 1'b1;
        exit_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_slow) begin
    if (rst) begin
      state_q <= IDLE;
      stall_q <= '0;
      count_q <= '0;
      entry_q <= 1'b0;
      exit_q  <= 1'b0;
      err_q   <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      stall_q <= stall_d;
      count_q <= count_d;
      entry_q <= entry_d;
      exit_q  <= exit_d;
      err_q   <= err_d;
      fault_q <= fault_d;
    end
  end

  assign bus.count       = count_q;
  assign bus.full        = (count_q == CNT_W'(CAPACITY));
  assign bus.empty       = (count_q == '0);
  assign bus.entry_pulse = entry_q;
  assign bus.exit_pulse  = exit_q;
  assign bus.err_pulse   = err_q;
  assign bus.fault       = fault_q;

endmodule

// File: tb/tb_car_flow_counter.sv
// Directed bench for car_flow_counter: table of beam patterns with hand-computed
// count/pulse expectations, plus sequences for saturation, stall timeout and reset.
module tb_car_flow_counter;

  localparam int CAP = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  car_flow_if #(.CNT_W(4)) bus ();

  car_flow_counter #(.CAPACITY(CAP), .CNT_W(4), .TIMEOUT_CYC(2000)) dut (
    .clk_slow (clk),
    .rst      (rst),
    .bus      (bus)
  );

  // pulse codes: 0 none, 1 entry, 2 exit, 3 err
  typedef struct {
    logic [1:0] ab;
    int         reps;
    int         cnt;
    int         pulse;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic [1:0] ab, input int reps, input int cnt, input int pulse);
    vec_t v;
    v.ab = ab; v.reps = reps; v.cnt = cnt; v.pulse = pulse;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Apply one beam pattern across one rising edge; outputs are read 1 ns later.
  task automatic tick(input logic [1:0] ab);
    bus.sensor_a = ab[1];
    bus.sensor_b = ab[0];
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string nm, input int cnt, input int pulse, input int flt);
    chk({nm, ".count"}, 32'(bus.count), cnt);
    chk({nm, ".entry"}, 32'(bus.entry_pulse), (pulse == 1) ? 1 : 0);
    chk({nm, ".exit"},  32'(bus.exit_pulse),  (pulse == 2) ? 1 : 0);
    chk({nm, ".err"},   32'(bus.err_pulse),   (pulse == 3) ? 1 : 0);
    chk({nm, ".full"},  32'(bus.full),  (cnt == CAP) ? 1 : 0);
    chk({nm, ".empty"}, 32'(bus.empty), (cnt == 0) ? 1 : 0);
    chk({nm, ".fault"}, 32'(bus.fault), flt);
  endtask

  // Three-step passage followed by 00; intermediate steps must not move count.
  task automatic pass(input string nm, input logic [1:0] s1, input logic [1:0] s2,
                      input logic [1:0] s3, input int prev, input int cnt, input int pulse);
    tick(s1); check_all(nm, prev, 0, 0);
    tick(s2); check_all(nm, prev, 0, 0);
    tick(s3); check_all(nm, prev, 0, 0);
    tick(2'b00); check_all(nm, cnt, pulse, 0);
  endtask

  initial begin
    bus.sensor_a = 1'b0;
    bus.sensor_b = 1'b0;

    // entry with 3 cycles per step
    add(2'b00,3,0,0); add(2'b10,3,0,0); add(2'b11,3,0,0); add(2'b01,3,0,0); add(2'b00,3,1,1);
    // exit back to empty
    add(2'b01,3,1,0); add(2'b11,3,1,0); add(2'b10,3,1,0); add(2'b00,3,0,2);
    // car backs out of the entry
    add(2'b10,2,0,0); add(2'b11,2,0,0); add(2'b10,2,0,0); add(2'b00,2,0,0);
    // exit while empty
    add(2'b01,1,0,0); add(2'b11,1,0,0); add(2'b10,1,0,0); add(2'b00,1,0,3);
    // abort from IN_A
    add(2'b10,1,0,0); add(2'b00,1,0,0);
    // entry, then exit with a back-step from OUT_BA to OUT_B
    add(2'b10,1,0,0); add(2'b11,1,0,0); add(2'b01,1,0,0); add(2'b00,1,1,1);
    add(2'b01,1,1,0); add(2'b11,1,1,0); add(2'b01,1,1,0); add(2'b11,1,1,0);
    add(2'b10,1,1,0); add(2'b00,1,0,2);
    // both beams at once from IDLE parks in WAIT_CLR until clear (no fault)
    add(2'b11,1,0,0); add(2'b10,2,0,0); add(2'b01,1,0,0); add(2'b00,1,0,0);
    // illegal jump IN_A -> 01 parks; 11 then clear, no count
    add(2'b10,1,0,0); add(2'b01,1,0,0); add(2'b11,1,0,0); add(2'b00,1,0,0);

    // reset state
    tick(2'b11);
    tick(2'b10);
    check_all("reset", 0, 0, 0);
    bus.sensor_a = 1'b0; bus.sensor_b = 1'b0;
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      for (int r = 0; r < tbl[i].reps; r++) begin
        tick(tbl[i].ab);
        check_all($sformatf("vec%0d.%0d", i, r), tbl[i].cnt, (r == 0) ? tbl[i].pulse : 0, 0);
      end
    end

    // fill to capacity, then one more entry saturates
    for (int i = 0; i < CAP; i++) pass($sformatf("fill%0d", i), 2'b10, 2'b11, 2'b01, i, i + 1, 1);
    pass("entry_full", 2'b10, 2'b11, 2'b01, CAP, CAP, 3);
    tick(2'b00); check_all("entry_full_after", CAP, 0, 0);

    // stall in IN_AB
    tick(2'b10); check_all("to_in_a", CAP, 0, 0);
    tick(2'b11); check_all("to_in_ab", CAP, 0, 0);
    repeat (1990) tick(2'b11);
    check_all("stall_early", CAP, 0, 0);
    repeat (15) tick(2'b11);
    check_all("stall_timeout", CAP, 0, 1);
    tick(2'b01); check_all("wait_hold", CAP, 0, 1);
    tick(2'b00); check_all("wait_clear", CAP, 0, 0);

    // reset during IN_B with count 5
    rst = 1'b1; tick(2'b00); rst = 1'b0;
    check_all("rst2", 0, 0, 0);
    for (int i = 0; i < 5; i++) pass($sformatf("to5_%0d", i), 2'b10, 2'b11, 2'b01, i, i + 1, 1);
    tick(2'b10); tick(2'b11); tick(2'b01);
    check_all("in_b5", 5, 0, 0);
    rst = 1'b1; tick(2'b00); rst = 1'b0;
    check_all("rst_in_b", 0, 0, 0);
    // from IDLE, 01 then 00 is an aborted exit; a leftover IN_B would count an entry
    tick(2'b01); check_all("post_rst_01", 0, 0, 0);
    tick(2'b00); check_all("post_rst_00", 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/car_flow_counter.md
CAR_FLOW_COUNTER -- requirements
Module: car_flow_counter

Interface
REQ-001 The block SHALL have parameter CAPACITY, default 15: maximum occupancy.
REQ-002 The block SHALL have parameter CNT_W, default 4: width of count; CAPACITY SHALL fit in CNT_W bits.
REQ-003 The block SHALL have parameter TIMEOUT_CYC, default 2000: stall limit in clk_slow cycles (2 s at 1 kHz).
REQ-004 The block SHALL have port clk_slow, input, 1 bit: the only clock (1 kHz); one clock; all logic on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port sensor_a, input, 1 bit: debounced outer sensor, 1 = beam blocked.
REQ-007 The block SHALL have port sensor_b, input, 1 bit: debounced inner sensor, 1 = beam blocked.
REQ-008 The block SHALL have port count, output, CNT_W bits: current occupancy, registered.
REQ-009 The block SHALL have port full, output, 1 bit: high when count == CAPACITY.
REQ-010 The block SHALL have port empty, output, 1 bit: high when count == 0.
REQ-011 The block SHALL have port entry_pulse, output, 1 bit: one-cycle pulse per accepted entry.
REQ-012 The block SHALL have port exit_pulse, output, 1 bit: one-cycle pulse per accepted exit.
REQ-013 The block SHALL have port err_pulse, output, 1 bit: one-cycle pulse per entry while full or exit while empty.
REQ-014 The block SHALL have port fault, output, 1 bit: high while the FSM is held in WAIT_CLR after a timeout.

Function
REQ-015 The FSM SHALL have states IDLE, IN_A, IN_AB, IN_B, OUT_B, OUT_BA, OUT_A and WAIT_CLR, and SHALL sample {sensor_a,sensor_b} (ab) every clk_slow edge.
REQ-016 In IDLE the FSM SHALL go to IN_A on ab=10, to OUT_B on ab=01, to WAIT_CLR on ab=11, and stay on 00.
REQ-017 In IN_A the FSM SHALL go to IN_AB on 11, to IDLE (abort, no count) on 00, to WAIT_CLR on 01, and stay on 10.
REQ-018 In IN_AB the FSM SHALL go to IN_B on 01, to IN_A on 10 (backing out), to WAIT_CLR on 00, and stay on 11.
REQ-019 In IN_B the FSM SHALL go to IDLE with an entry event on 00, to IN_AB on 11, to WAIT_CLR on 10, and stay on 01.
REQ-020 OUT_B, OUT_BA and OUT_A SHALL mirror IN_A, IN_AB and IN_B with the roles of a and b swapped, and OUT_A with 00 SHALL go to IDLE with an exit event.
REQ-021 In WAIT_CLR the FSM SHALL go to IDLE on 00 and stay otherwise, with no count change.
REQ-022 On an entry event with count < CAPACITY, count SHALL increment and entry_pulse SHALL be 1 on the same edge the FSM leaves IN_B.
REQ-023 On an entry event with count == CAPACITY, count SHALL hold and err_pulse SHALL be 1 for one cycle.
REQ-024 On an exit event with count > 0, count SHALL decrement and exit_pulse SHALL be 1; with count == 0, count SHALL hold and err_pulse SHALL be 1.
REQ-025 Count SHALL never wrap: it SHALL stay within 0..CAPACITY.
REQ-026 At most one of entry_pulse, exit_pulse and err_pulse SHALL be high in any cycle, and each SHALL be high for exactly one cycle per event.
REQ-027 A stall timer SHALL clear on every state change and in IDLE, and SHALL count cycles spent in any other non-WAIT_CLR state.
REQ-028 When the stall timer reaches TIMEOUT_CYC, the FSM SHALL go to WAIT_CLR and set fault.
REQ-029 Fault SHALL clear on the edge that WAIT_CLR exits to IDLE.
REQ-030 Full and empty SHALL be derived from the registered count, with no extra latency versus count.

Reset
REQ-031 While rst=1 on a clock edge, the block SHALL set state=IDLE, count=0, the stall timer to 0, and entry_pulse, exit_pulse, err_pulse and fault to 0, giving full=0 and empty=1.
REQ-032 Reset SHALL take priority over any event in the same cycle.
REQ-033 A reset mid-sequence SHALL discard the partial passage, and the FSM SHALL return to IDLE; if sensors are still blocked after reset, IDLE SHALL follow REQ-016 from that point on.

Verification
REQ-034 The bench SHALL verify that after reset, ab sequence 00,10,11,01,00 (3 cycles each) gives count 0->1 and entry_pulse for 1 cycle on the edge sampling the final 00.
REQ-035 The bench SHALL verify that, from count=1, ab sequence 01,11,10,00 gives count=0, exit_pulse for 1 cycle, and empty=1.
REQ-036 The bench SHALL verify that ab sequence 10,11,10,00 (car backs out) gives no pulse and count unchanged.
REQ-037 The bench SHALL verify that, with count=15, a full entry sequence gives err_pulse for 1 cycle and count held at 15 with full=1; with count=0, an exit sequence gives err_pulse and count held at 0.
REQ-038 The bench SHALL verify that holding ab=11 for 2000 cycles from IN_AB sets fault=1, and that a following ab=00 gives IDLE and fault=0 with count unchanged.
REQ-039 The bench SHALL verify that rst=1 while in IN_B with count=5 gives count=0, no entry_pulse, and state IDLE on the next edge.
